// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and Tx-datapath signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_load;
  logic                    tx_start;
  logic                    tx_done;
  logic [SRC_W-1:0]        cur_src;
  logic                    busy;
  logic                    timeout_err;

  modport slave (
    input  req, req_data, tx_done,
    output grant, tx_data, tx_load, tx_start, cur_src, busy, timeout_err
  );

  modport master (
    output req, req_data, tx_done,
    input  grant, tx_data, tx_load, tx_start, cur_src, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin UART Tx arbiter/sequencer; SEND watchdog enabled by TX_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    last_q, last_d;
  logic [SRC_W-1:0]    cur_src_q, cur_src_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                win_found;
  logic [SRC_W-1:0]    win_idx;
  logic [SRC_W-1:0]    cand;
  logic                timeout_hit;

  logic [N_REQ-1:0]    grant_o;
  logic                tx_load_o;
  logic                tx_start_o;
  logic                busy_o;
  logic                timeout_err_o;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Watchdog counter: zero on SEND entry, one count per SEND cycle
  always_comb begin
    cnt_d = '0;
    if (state_q == S_SEND) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == S_SEND) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // The limit only matters when the watchdog is built; SEND waits for tx_done forever
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // Round-robin search starting just after the last winner, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SRC_W'((int'(last_q) + k) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register and captured frame context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= SRC_W'(N_REQ - 1);
      cur_src_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_src_q <= cur_src_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Next-state logic; capture of winner and its byte only on the IDLE->LOAD edge
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_src_d = cur_src_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_LOAD;
          last_d    = win_idx;
          cur_src_d = win_idx;
          tx_data_d = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_SEND;
      S_SEND: begin
        if (bus.tx_done || timeout_hit) begin
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decoded from the registered state; timeout loses to a same-cycle tx_done
  always_comb begin
    grant_o       = '0;
    tx_load_o     = 1'b0;
    tx_start_o    = 1'b0;
    busy_o        = (state_q != S_IDLE);
    timeout_err_o = timeout_hit && !bus.tx_done;
    if (state_q == S_LOAD) begin
      grant_o[cur_src_q] = 1'b1;
      tx_load_o          = 1'b1;
    end
    if (state_q == S_START) begin
      tx_start_o = 1'b1;
    end
  end

  assign bus.grant       = grant_o;
  assign bus.tx_load     = tx_load_o;
  assign bus.tx_start    = tx_start_o;
  assign bus.busy        = busy_o;
  assign bus.timeout_err = timeout_err_o;
  assign bus.tx_data     = tx_data_q;
  assign bus.cur_src     = cur_src_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (TIMEOUT_CYC=16)
module tb_uart_tx_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(
    .N_REQ       (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [3:0] g, input logic ld,
                             input logic st, input logic bz);
    chk({tag, ".grant"},    32'(bus.grant),    32'(g));
    chk({tag, ".tx_load"},  32'(bus.tx_load),  32'(ld));
    chk({tag, ".tx_start"}, 32'(bus.tx_start), 32'(st));
    chk({tag, ".busy"},     32'(bus.busy),     32'(bz));
  endtask

  // From a LOAD cycle: START, one SEND cycle with tx_done, GAP, back to IDLE
  task automatic run_tail(input string tag);
    step();
    chk_strobes({tag, ".start"}, 4'b0000, 1'b0, 1'b1, 1'b1);
    step();
    chk_strobes({tag, ".send"}, 4'b0000, 1'b0, 1'b0, 1'b1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk_strobes({tag, ".gap"}, 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    chk_strobes({tag, ".idle"}, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] order [5];
    logic [7:0] exp_byte;
    checks = 0;
    errors = 0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    step();
    step();

    // Reset state
    chk_strobes("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst.tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst.cur_src", 32'(bus.cur_src), 32'h0);
    chk("rst.timeout_err", 32'(bus.timeout_err), 32'h0);

    // Single request from requester 0
    reset        = 1'b0;
    bus.req      = 4'b0001;
    bus.req_data = 32'h000000A5;
    step();
    chk_strobes("t1.load", 4'b0001, 1'b1, 1'b0, 1'b1);
    chk("t1.tx_data", 32'(bus.tx_data), 32'hA5);
    chk("t1.cur_src", 32'(bus.cur_src), 32'h0);
    bus.req = 4'b0000;
    run_tail("t1");
    chk("t1.hold_data", 32'(bus.tx_data), 32'hA5);

    // All four requesting: rotation 0,1,2,3,0 with tx_done 10 cycles after tx_start
    reset = 1'b1;
    step();
    reset        = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = 32'h44332211;
    step();
    for (int f = 0; f < 5; f++) begin
      exp_byte = 8'h11 * (8'(order[f]) + 8'd1);
      chk_strobes("t2.load", 4'b0001 << order[f], 1'b1, 1'b0, 1'b1);
      chk("t2.tx_data", 32'(bus.tx_data), 32'(exp_byte));
      chk("t2.cur_src", 32'(bus.cur_src), 32'(order[f]));
      if (f == 4) bus.req = 4'b0000;
      step();
      chk_strobes("t2.start", 4'b0000, 1'b0, 1'b1, 1'b1);
      repeat (10) step();
      chk_strobes("t2.send", 4'b0000, 1'b0, 1'b0, 1'b1);
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      chk_strobes("t2.gap", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      chk_strobes("t2.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      if (f < 4) step();
    end

    // Spurious tx_done in LOAD ignored; requests raised during SEND wait for IDLE
    bus.req = 4'b0100;
    step();
    chk_strobes("t3.load2", 4'b0100, 1'b1, 1'b0, 1'b1);
    chk("t3.tx_data2", 32'(bus.tx_data), 32'h33);
    bus.tx_done = 1'b1;
    bus.req     = 4'b0000;
    step();
    bus.tx_done = 1'b0;
    chk_strobes("t3.start", 4'b0000, 1'b0, 1'b1, 1'b1);
    step();
    bus.req = 4'b1001;
    repeat (3) begin
      chk_strobes("t3.send", 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk_strobes("t3.gap", 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk_strobes("t3.load3", 4'b1000, 1'b1, 1'b0, 1'b1);
    chk("t3.tx_data3", 32'(bus.tx_data), 32'h44);
    chk("t3.cur_src3", 32'(bus.cur_src), 32'h3);
    bus.req = 4'b0001;
    run_tail("t3.f3");
    step();
    chk_strobes("t3.load0", 4'b0001, 1'b1, 1'b0, 1'b1);
    chk("t3.tx_data0", 32'(bus.tx_data), 32'h11);
    bus.req = 4'b0000;
    run_tail("t3.f0");

    // Reset in SEND: outputs cleared, priority pointer back to N_REQ-1
    bus.req = 4'b0100;
    step();
    chk_strobes("t4.load", 4'b0100, 1'b1, 1'b0, 1'b1);
    bus.req = 4'b0000;
    step();
    step();
    chk_strobes("t4.send", 4'b0000, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    chk_strobes("t4.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t4.rst.tx_data", 32'(bus.tx_data), 32'h0);
    chk("t4.rst.cur_src", 32'(bus.cur_src), 32'h0);
    chk("t4.rst.timeout_err", 32'(bus.timeout_err), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b1100;
    step();
    chk_strobes("t4.load2", 4'b0100, 1'b1, 1'b0, 1'b1);
    chk("t4.cur_src", 32'(bus.cur_src), 32'h2);
    chk("t4.tx_data", 32'(bus.tx_data), 32'h33);
    bus.req = 4'b0000;
    run_tail("t4");

    // Withheld tx_done with requesters 0 and 1 pending
    bus.req = 4'b0011;
    step();
    chk_strobes("t5.load0", 4'b0001, 1'b1, 1'b0, 1'b1);
    step();
    chk_strobes("t5.start", 4'b0000, 1'b0, 1'b1, 1'b1);
    step();
`ifdef TX_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      chk("t5.no_timeout", 32'(bus.timeout_err), 32'h0);
      step();
    end
    chk("t5.timeout16", 32'(bus.timeout_err), 32'h1);
    chk("t5.busy16", 32'(bus.busy), 32'h1);
    step();
    chk("t5.gap.timeout", 32'(bus.timeout_err), 32'h0);
    chk_strobes("t5.gap", 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    chk_strobes("t5.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk_strobes("t5.load1", 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("t5.tx_data1", 32'(bus.tx_data), 32'h22);
    bus.req = 4'b0000;
    step();
    step();
    repeat (15) step();
    bus.tx_done = 1'b1;
    chk("t5.done_at_limit", 32'(bus.timeout_err), 32'h0);
    step();
    bus.tx_done = 1'b0;
    chk("t5.gap2.timeout", 32'(bus.timeout_err), 32'h0);
    chk_strobes("t5.gap2", 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    chk_strobes("t5.idle2", 4'b0000, 1'b0, 1'b0, 1'b0);
`else
    for (int i = 1; i <= 30; i++) begin
      chk("t5.no_timeout", 32'(bus.timeout_err), 32'h0);
      chk("t5.stay_send", 32'(bus.busy), 32'h1);
      step();
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk_strobes("t5.gap", 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    chk_strobes("t5.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk_strobes("t5.load1", 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("t5.tx_data1", 32'(bus.tx_data), 32'h22);
    bus.req = 4'b0000;
    run_tail("t5.f1");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
